id_ex_latch: RTL and testbench
==============================

Name: id_ex_latch

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the DECODE-stage control unit and register file.
- Each cycle it captures the decoded control fields WB/M/EX, the operands, the sign-extended immediate and the register specifiers, and presents them to EXECUTE.
- It contains the load-use hazard detector. The detector stalls PC and IF/ID and inserts a bubble.
- It zeroes control fields on a branch flush and keeps saturating bubble/flush statistics counters.

Parameters:
- DATA_W, 32, width of npc/operand/immediate datapath
- CNT_W, 16, width of each statistics counter

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- ctlwb_in  input  2  WB field from control: [1]=RegWrite, [0]=MemToReg
- ctlm_in  input  3  M field: [2]=Branch, [1]=MemRead, [0]=MemWrite
- ctlex_in  input  4  EX field: [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
- npc_in  input  DATA_W  PC+4 from IF/ID
- readdat1_in  input  DATA_W  register file port 1 (rs)
- readdat2_in  input  DATA_W  register file port 2 (rt)
- signext_in  input  DATA_W  sign-extended immediate
- rs_in  input  5  instr[25:21] from IF/ID
- rt_in  input  5  instr[20:16]
- rd_in  input  5  instr[15:11]
- flush  input  1  branch taken in MEM; squash the instruction in ID
- wb_out  output  2  registered WB field
- m_out  output  3  registered M field
- ex_out  output  4  registered EX field
- npc_out, readdat1_out, readdat2_out, signext_out  output  DATA_W  registered data
- rs_out, rt_out, rd_out  output  5  registered specifiers
- stall  output  1  hold PC and IF/ID this cycle
- bubble_cnt  output  CNT_W  number of load-use bubbles inserted
- flush_cnt  output  CNT_W  number of flush-squashed slots

Behaviour:
- Reset:
  - On a rising edge with rst=1, every registered output goes to 0: wb/m/ex, data, specifiers and both counters.
  - stall is 0 while registers are in the reset state.
  - rst has priority over everything, including mid-stall and mid-flush.
- Hazard detect:
  - Purely combinational from registered state and current inputs:
    stall = m_out[1] & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
  - No register in the path. Same-cycle response.
- Update priority on each rising edge (rst=0):
  - flush=1: wb/m/ex <= 0; data and specifiers capture inputs; flush_cnt increments. This applies even when stall=1, and no bubble is counted.
  - else stall=1: wb/m/ex <= 0 (bubble); data and specifiers capture inputs; bubble_cnt increments.
  - else: all fields capture inputs (one-cycle latency, input to output).
- Stall duration:
  - A single load-use stall lasts exactly 1 cycle, because the bubble clears m_out[1].
  - Back-to-back loads each produce at most one bubble.
- Counters:
  - CNT_W-bit and saturating: hold at all-ones and never wrap.
  - Both are cleared only by rst.
- Register $0:
  - A load targeting $0 (rt_out=0) never stalls.
- No enable or handshake beyond stall/flush. The block advances every cycle.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with nonzero inputs.
  - Required: all outputs 0, stall=0, bubble_cnt=0, flush_cnt=0.
- R-type passthrough:
  - Stimulus: ctlwb_in=2'b10, ctlm_in=3'b000, ctlex_in=4'b1100, readdat1_in=32'h0000_0005, rd_in=5'd8.
  - Required: next edge wb_out=10, m_out=000, ex_out=1100, readdat1_out=5, rd_out=8, stall=0.
- Load-use:
  - Stimulus: lw (ctlwb_in=11, ctlm_in=010, ctlex_in=0001, rt_in=9) latched; next ID instruction has rs_in=9.
  - Required: stall=1 that cycle; next edge wb/m/ex=0, bubble_cnt=1; stall=0 the following cycle.
- No false hazard:
  - Stimulus: lw with rt=0 followed by rs_in=0; and lw rt=9 followed by rs_in=4, rt_in=5.
  - Required: stall=0 in both cases, bubble_cnt unchanged.
- Flush vs stall:
  - Stimulus: flush=1 asserted in the same cycle as a load-use stall.
  - Required: next edge wb/m/ex=0, flush_cnt=1, bubble_cnt unchanged.
- Saturation / reset mid-operation:
  - Stimulus: with CNT_W=2, force 5 bubbles, then assert rst while stall=1.
  - Required: bubble_cnt reads 3 after the 3rd bubble and stays 3; after rst all outputs are 0 and stall=0.

Source files
------------

// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with load-use stall detection, flush squash and saturating stats
module id_ex_latch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [3:0]        ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] readdat1_in,
  input  logic [DATA_W-1:0] readdat2_in,
  input  logic [DATA_W-1:0] signext_in,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  output logic [1:0]        wb_out,
  output logic [2:0]        m_out,
  output logic [3:0]        ex_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] readdat1_out,
  output logic [DATA_W-1:0] readdat2_out,
  output logic [DATA_W-1:0] signext_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [1:0]        wb_q, wb_d;
  logic [2:0]        m_q, m_d;
  logic [3:0]        ex_q, ex_d;
  logic [DATA_W-1:0] npc_q, npc_d, rd1_q, rd1_d, rd2_q, rd2_d, se_q, se_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d, flush_q, flush_d;
  logic              kill;
  always_comb begin
    stall    = m_q[1] & (rt_q != 5'd0) & ((rt_q == rs_in) | (rt_q == rt_in));
    kill     = flush | stall;
    wb_d     = kill ? 2'd0 : ctlwb_in;
    m_d      = kill ? 3'd0 : ctlm_in;
    ex_d     = kill ? 4'd0 : ctlex_in;
    npc_d    = npc_in;
    rd1_d    = readdat1_in;
    rd2_d    = readdat2_in;
    se_d     = signext_in;
    rs_d     = rs_in;
    rt_d     = rt_in;
    rd_d     = rd_in;
    // a flush wins over a coincident stall, so only flush_cnt moves then
    flush_d  = (flush && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
    bubble_d = (!flush && stall && !(&bubble_q)) ? bubble_q + 1'b1 : bubble_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      m_q      <= '0;
      ex_q     <= '0;
      npc_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      se_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
      npc_q    <= npc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      se_q     <= se_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end
  assign wb_out       = wb_q;
  assign m_out        = m_q;
  assign ex_out       = ex_q;
  assign npc_out      = npc_q;
  assign readdat1_out = rd1_q;
  assign readdat2_out = rd2_q;
  assign signext_out  = se_q;
  assign rs_out       = rs_q;
  assign rt_out       = rt_q;
  assign rd_out       = rd_q;
  assign bubble_cnt   = bubble_q;
  assign flush_cnt    = flush_q;
endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: scoreboard bench for id_ex_latch, with a 2-bit-counter copy for saturation
module tb_id_ex_latch;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0]  ctlwb_in = '0;
  logic [2:0]  ctlm_in = '0;
  logic [3:0]  ctlex_in = '0;
  logic [31:0] npc_in = '0, readdat1_in = '0, readdat2_in = '0, signext_in = '0;
  logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;
  logic [1:0]  wb_out, wb2;
  logic [2:0]  m_out, m2;
  logic [3:0]  ex_out, ex2;
  logic [31:0] npc_out, readdat1_out, readdat2_out, signext_out, npc2, r1_2, r2_2, se2;
  logic [4:0]  rs_out, rt_out, rd_out, rs2, rt2, rd2;
  logic        stall, stall2;
  logic [15:0] bubble_cnt, flush_cnt;
  logic [1:0]  bubble2, flush2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_ex_latch dut (
    .clk(clk), .rst(rst), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in), .signext_in(signext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out), .npc_out(npc_out),
    .readdat1_out(readdat1_out), .readdat2_out(readdat2_out), .signext_out(signext_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .stall(stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));
  id_ex_latch #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in), .signext_in(signext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .wb_out(wb2), .m_out(m2), .ex_out(ex2), .npc_out(npc2),
    .readdat1_out(r1_2), .readdat2_out(r2_2), .signext_out(se2),
    .rs_out(rs2), .rt_out(rt2), .rd_out(rd2), .stall(stall2),
    .bubble_cnt(bubble2), .flush_cnt(flush2));
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, r1, r2, se;
    logic [4:0]  rs, rt, rd;
    logic [15:0] bc, fc;
    logic [1:0]  bc2, fc2;
  } exp_t;
  exp_t q[$];
  exp_t mdl = '0;
  bit   mdl_ok = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drv(input logic [1:0] w, input logic [2:0] mm, input logic [3:0] e,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic [31:0] r1, input logic f);
    ctlwb_in = w; ctlm_in = mm; ctlex_in = e;
    rs_in = s; rt_in = t; rd_in = d; flush = f;
    readdat1_in = r1; npc_in = $urandom; readdat2_in = $urandom; signext_in = $urandom;
  endtask
  task automatic cycle();
    exp_t n, g;
    logic st;
    #1;
    st = mdl.m[1] && (mdl.rt != 5'd0) && (mdl.rt == rs_in || mdl.rt == rt_in);
    if (mdl_ok) begin
      chk("stall", {31'd0, stall}, {31'd0, st});
      chk("stall2", {31'd0, stall2}, {31'd0, st});
    end
    n = mdl;
    n.wb = (flush || st) ? 2'd0 : ctlwb_in;
    n.m  = (flush || st) ? 3'd0 : ctlm_in;
    n.ex = (flush || st) ? 4'd0 : ctlex_in;
    n.npc = npc_in; n.r1 = readdat1_in; n.r2 = readdat2_in; n.se = signext_in;
    n.rs = rs_in; n.rt = rt_in; n.rd = rd_in;
    if (flush) begin
      if (mdl.fc != 16'hFFFF) n.fc = mdl.fc + 16'd1;
      if (mdl.fc2 != 2'd3) n.fc2 = mdl.fc2 + 2'd1;
    end else if (st) begin
      if (mdl.bc != 16'hFFFF) n.bc = mdl.bc + 16'd1;
      if (mdl.bc2 != 2'd3) n.bc2 = mdl.bc2 + 2'd1;
    end
    if (rst) n = '0;
    q.push_back(n);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("wb", {30'd0, wb_out}, {30'd0, g.wb});
    chk("m", {29'd0, m_out}, {29'd0, g.m});
    chk("ex", {28'd0, ex_out}, {28'd0, g.ex});
    chk("npc", npc_out, g.npc);
    chk("rd1", readdat1_out, g.r1);
    chk("rd2", readdat2_out, g.r2);
    chk("sext", signext_out, g.se);
    chk("rs", {27'd0, rs_out}, {27'd0, g.rs});
    chk("rt", {27'd0, rt_out}, {27'd0, g.rt});
    chk("rd", {27'd0, rd_out}, {27'd0, g.rd});
    chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, g.bc});
    chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, g.fc});
    chk("bubble_cnt2", {30'd0, bubble2}, {30'd0, g.bc2});
    chk("flush_cnt2", {30'd0, flush2}, {30'd0, g.fc2});
    mdl = g;
    mdl_ok = 1'b1;
  endtask
  initial begin
    rst = 1'b1;
    drv(2'b11, 3'b111, 4'b1111, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 1'b1);
    cycle();
    drv(2'b11, 3'b111, 4'b1111, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 1'b1);
    cycle();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    drv(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd8, 32'h0000_0005, 1'b0);
    cycle();
    chk("rtype_rd1", readdat1_out, 32'd5);
    drv(2'b11, 3'b010, 4'b0001, 5'd3, 5'd9, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd9, 5'd7, 5'd10, $urandom, 1'b0);
    cycle();
    chk("lu_bubble", {16'd0, bubble_cnt}, 32'd1);
    cycle();
    drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b11, 3'b010, 4'b0001, 5'd9, 5'd10, 5'd0, $urandom, 1'b0);
    cycle();
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd10, 5'd11, 5'd12, $urandom, 1'b0);
    cycle();
    cycle();
    drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd0, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd3, $urandom, 1'b0);
    cycle();
    drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd4, 5'd5, 5'd6, $urandom, 1'b0);
    cycle();
    drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd9, 5'd5, 5'd6, $urandom, 1'b1);
    cycle();
    chk("flush_cnt_once", {16'd0, flush_cnt}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, $urandom, 1'b0);
      cycle();
      drv(2'b10, 3'b000, 4'b1100, 5'd9, 5'd2, 5'd3, $urandom, 1'b0);
      cycle();
    end
    chk("sat_bubble2", {30'd0, bubble2}, 32'd3);
    for (int i = 0; i < 40; i++) begin
      drv(2'($urandom), 3'($urandom), 4'($urandom), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
      cycle();
    end
    drv(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, $urandom, 1'b0);
    cycle();
    drv(2'b10, 3'b000, 4'b1100, 5'd9, 5'd2, 5'd3, $urandom, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drv(2'b10, 3'b000, 4'b1100, 5'd9, 5'd9, 5'd3, $urandom, 1'b0);
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
